mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 141 ++++++++++++++
 tb/tb_mdu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and pipeline stall generation.
// Operands are latched on acceptance; the result is written when the busy counter expires.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic signed [63:0] sa, sb;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  // Arithmetic works only from the latched operands, so a/b never reach hi/lo directly.
  always_comb begin
    sa     = {{32{a_q[31]}}, a_q};
    sb     = {{32{b_q[31]}}, b_q};
    prod_s = 64'(sa * sb);
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    quot_s = 32'd0;
    rem_s  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (b_q != 32'd0) begin
      quot_u = a_q / b_q;
      rem_u  = a_q % b_q;
      if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        quot_s = 32'($signed(a_q) / $signed(b_q));
        rem_s  = 32'($signed(a_q) % $signed(b_q));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = md_op;
              a_d     = a;
              b_d     = b;
              cnt_d   = (md_op == OP_MULT || md_op == OP_MULTU) ?
                        5'(MULT_CYCLES) : 5'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: if (b_q != 32'd0) begin
              hi_d = rem_s;
              lo_d = quot_s;
            end
            OP_DIVU: if (b_q != 32'd0) begin
              hi_d = rem_u;
              lo_d = quot_u;
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == S_BUSY);
  assign stall = md_use & (busy | (start & (md_op <= 3'd3)));

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table plus hand-written corner sequences.
// Expected hi/lo pairs go through a scoreboard queue and are popped when busy falls.
module tb_mdu;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];
  logic [31:0] mHi, mLo;
  vec_t vecs[10];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .md_use(md_use), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Start one multi-cycle op; check latency, held hi/lo and the scoreboard result.
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] opA,
                               input logic [31:0] opB, input logic [31:0] expHi, input logic [31:0] expLo);
    res_t exp, got;
    int cnt, n;
    n = (op < 3'd2) ? 5 : 10;
    exp.hi = expHi;
    exp.lo = expLo;
    sb.push_back(exp);
    start = 1'b1; md_op = op; a = opA; b = opB;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; md_op = 3'($urandom_range(0, 3));
    checkOutput({name, "_busy_rise"}, 32'(busy), 32'd1);
    checkOutput({name, "_hold_hi"}, hi, mHi);
    checkOutput({name, "_hold_lo"}, lo, mLo);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick();
    end
    checkOutput({name, "_cycles"}, 32'(cnt), 32'(n));
    got = sb.pop_front();
    checkOutput({name, "_hi"}, hi, got.hi);
    checkOutput({name, "_lo"}, lo, got.lo);
    mHi = got.hi;
    mLo = got.lo;
  endtask

  task automatic moveTo(input logic [2:0] op, input logic [31:0] val);
    start = 1'b1; md_op = op; a = val; b = 32'd0;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    logic stallOk;
    reset = 1'b0; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0; md_use = 1'b0;
    mHi = 32'd0; mLo = 32'd0;

    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[5] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[7] = '{3'd1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[8] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[9] = '{3'd2, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2};

    // Reset overrides a simultaneous mthi.
    start = 1'b1; md_op = 3'd4; a = 32'hDEAD_BEEF;
    tick();
    tick();
    start = 1'b0;
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    reset = 1'b1;
    tick();

    // Table ops run back to back: each starts at the edge right after busy falls.
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].expHi, vecs[i].expLo);
    end

    // Divide by zero leaves hi/lo untouched.
    moveTo(3'd4, 32'h0000_0011);
    moveTo(3'd5, 32'h0000_0022);
    mHi = 32'h11; mLo = 32'h22;
    checkOutput("mt_hi", hi, 32'h11);
    checkOutput("mt_lo", lo, 32'h22);
    applyStimulus("divu_by0", 3'd3, 32'd5, 32'd0, 32'h11, 32'h22);
    applyStimulus("div_by0", 3'd2, 32'hFFFF_FFF0, 32'd0, 32'h11, 32'h22);

    // Zero-latency mthi, and stall behaviour idle and mid-operation.
    md_use = 1'b1;
    checkOutput("stall_idle_nostart", 32'(stall), 32'd0);
    moveTo(3'd4, 32'h0000_1234);
    checkOutput("mthi_hi", hi, 32'h1234);
    checkOutput("mthi_busy", 32'(busy), 32'd0);
    mHi = 32'h1234;
    start = 1'b1; md_op = 3'd0; a = 32'd6; b = 32'd7;
    #1;
    checkOutput("stall_on_start", 32'(stall), 32'd1);
    md_use = 1'b0;
    #1;
    checkOutput("stall_nouse_start", 32'(stall), 32'd0);
    md_use = 1'b1;
    tick();
    start = 1'b0;
    stallOk = 1'b1;
    cnt = 0;
    while (busy && cnt < 40) begin
      if (stall !== 1'b1) stallOk = 1'b0;
      cnt++;
      tick();
    end
    checkOutput("stall_all_busy", 32'(stallOk), 32'd1);
    checkOutput("stall_mult_cycles", 32'(cnt), 32'd5);
    checkOutput("stall_mult_lo", lo, 32'd42);
    checkOutput("stall_after", 32'(stall), 32'd0);
    start = 1'b1; md_op = 3'd2; a = 32'd9; b = 32'd2;
    md_use = 1'b0;
    tick();
    start = 1'b0;
    checkOutput("nouse_busy", 32'(busy), 32'd1);
    checkOutput("nouse_stall", 32'(stall), 32'd0);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick();
    end
    checkOutput("nouse_div_lo", lo, 32'd4);
    checkOutput("nouse_div_hi", hi, 32'd1);
    mHi = 32'd1; mLo = 32'd4;

    // Reserved op codes change nothing.
    md_use = 1'b1;
    start = 1'b1; md_op = 3'd6; a = 32'hAAAA_AAAA;
    #1;
    checkOutput("rsv_stall", 32'(stall), 32'd0);
    tick();
    md_op = 3'd7;
    tick();
    start = 1'b0; md_use = 1'b0;
    checkOutput("rsv_busy", 32'(busy), 32'd0);
    checkOutput("rsv_hi", hi, 32'd1);
    checkOutput("rsv_lo", lo, 32'd4);

    // Start while busy is ignored; result reflects the first op only.
    start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;
    tick();
    a = 32'd100; b = 32'd100;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick();
    end
    start = 1'b0;
    checkOutput("overlap_cycles", 32'(cnt), 32'd5);
    checkOutput("overlap_hi", hi, 32'd0);
    checkOutput("overlap_lo", lo, 32'd12);

    // Reset on the third busy cycle of a div aborts it.
    moveTo(3'd4, 32'h55);
    moveTo(3'd5, 32'h66);
    start = 1'b1; md_op = 3'd3; a = 32'h100; b = 32'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    repeat (15) tick();
    checkOutput("abort_late_hi", hi, 32'd0);
    checkOutput("abort_late_lo", lo, 32'd0);
    checkOutput("abort_late_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
